// File: rtl/fsk_frame_receiver_pkg.sv
// Shared types and defaults for the FSK frame receiver.
`timescale 1ns/1ps
package fsk_frame_receiver_pkg;

    typedef enum logic [1:0] {
        StHunt,
        StLen,
        StPayload,
        StChk
    } rx_state_e;

    localparam logic [15:0] DefaultSyncWord = 16'hD391;
    localparam int unsigned DefaultMaxLen   = 64;
    localparam int unsigned LenWidth        = $clog2(DefaultMaxLen + 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/fsk_frame_receiver_bit_sync.sv
// Bit timing recovery: input synchronizer, edge-aligned phase counter, majority
// sampler and idle-bit watchdog.
`timescale 1ns/1ps
module fsk_frame_receiver_bit_sync
    import fsk_frame_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 50,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic demod_bit,
    output logic bit_tick,
    output logic bit_val,
    output logic timeout
);

    localparam int unsigned PhW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdleW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [PhW-1:0]   HalfBit  = PhW'(CLKS_PER_BIT / 2);
    localparam logic [PhW-1:0]   LastPh   = PhW'(CLKS_PER_BIT - 1);
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT_BITS);

    logic             meta_q;
    logic             bit_s_q;
    logic             bit_s_prev_q;
    logic             bit_s_prev2_q;
    logic [PhW-1:0]   phase_q, phase_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic             edge_det;

    assign edge_det = bit_s_q ^ bit_s_prev_q;
    // A realigning edge suppresses the tick that would otherwise fire this cycle.
    assign bit_tick = !edge_det && (phase_q == HalfBit);
    assign bit_val  = maj3(bit_s_q, bit_s_prev_q, bit_s_prev2_q);
    assign timeout  = (idle_q == IdleMax);

    always_comb begin
        phase_d = phase_q + PhW'(1);
        idle_d  = idle_q;
        if (edge_det) begin
            phase_d = PhW'(1);
            idle_d  = '0;
        end else begin
            if (phase_q == LastPh) begin
                phase_d = '0;
            end
            if (bit_tick && (idle_q != IdleMax)) begin
                idle_d = idle_q + IdleW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q        <= 1'b0;
            bit_s_q       <= 1'b0;
            bit_s_prev_q  <= 1'b0;
            bit_s_prev2_q <= 1'b0;
            phase_q       <= '0;
            idle_q        <= '0;
        end else begin
            meta_q        <= demod_bit;
            bit_s_q       <= meta_q;
            bit_s_prev_q  <= bit_s_q;
            bit_s_prev2_q <= bit_s_prev_q;
            phase_q       <= phase_d;
            idle_q        <= idle_d;
        end
    end

endmodule

// File: rtl/fsk_frame_receiver.sv
// FSK frame receiver: sync-word hunt, then [LEN][payload x LEN][CHK] deframing with
// additive checksum over LEN and payload.
`timescale 1ns/1ps
module fsk_frame_receiver
    import fsk_frame_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 50,
    parameter logic [15:0] SYNC_WORD    = DefaultSyncWord,
    parameter int unsigned MAX_LEN      = DefaultMaxLen,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       demod_bit,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       sync_locked,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam int unsigned RemW = $clog2(MAX_LEN + 1);

    logic bit_tick, bit_val, timeout;

    fsk_frame_receiver_bit_sync #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_bit_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .demod_bit(demod_bit),
        .bit_tick (bit_tick),
        .bit_val  (bit_val),
        .timeout  (timeout)
    );

    rx_state_e       state_q, state_d;
    logic [15:0]     sr_q, sr_d, sr_next;
    logic [7:0]      byte_sr_q, byte_sr_d, byte_next;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      sum_q, sum_d;
    logic [RemW-1:0] rem_q, rem_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            locked_q, locked_d;
    logic            done_q, done_d;
    logic            ok_q, ok_d;
    logic            err_q, err_d;
    logic            byte_end;

    assign byte_next = {byte_sr_q[6:0], bit_val};
    assign sr_next   = {sr_q[14:0], bit_val};
    assign byte_end  = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        byte_sr_d   = byte_sr_q;
        bit_cnt_d   = bit_cnt_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        locked_d    = locked_q;
        done_d      = 1'b0;
        ok_d        = ok_q;
        err_d       = 1'b0;

        if (timeout && (state_q != StHunt)) begin
            state_d  = StHunt;
            locked_d = 1'b0;
            err_d    = 1'b1;
        end else if (bit_tick) begin
            if (state_q == StHunt) begin
                if (sr_next == SYNC_WORD) begin
                    state_d   = StLen;
                    locked_d  = 1'b1;
                    sr_d      = '0;
                    bit_cnt_d = '0;
                end else begin
                    sr_d = sr_next;
                end
            end else begin
                byte_sr_d = byte_next;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_end) begin
                    case (state_q)
                        StLen: begin
                            if ((byte_next == 8'd0) || (32'(byte_next) > MAX_LEN)) begin
                                state_d  = StHunt;
                                locked_d = 1'b0;
                                err_d    = 1'b1;
                            end else begin
                                sum_d   = byte_next;
                                rem_d   = RemW'(byte_next);
                                state_d = StPayload;
                            end
                        end
                        StPayload: begin
                            out_data_d  = byte_next;
                            out_valid_d = 1'b1;
                            sum_d       = sum_q + byte_next;
                            rem_d       = rem_q - RemW'(1);
                            if (rem_q == RemW'(1)) begin
                                out_last_d = 1'b1;
                                state_d    = StChk;
                            end
                        end
                        StChk: begin
                            done_d   = 1'b1;
                            ok_d     = (byte_next == sum_q);
                            err_d    = (byte_next != sum_q);
                            locked_d = 1'b0;
                            state_d  = StHunt;
                        end
                        default: state_d = StHunt;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            sr_q        <= '0;
            byte_sr_q   <= '0;
            bit_cnt_q   <= '0;
            sum_q       <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            byte_sr_q   <= byte_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign sync_locked = locked_q;
    assign frame_done  = done_q;
    assign frame_ok    = ok_q;
    assign frame_err   = err_q;

endmodule
